ecc_point_check: RTL and testbench

- Downstream consumer of point_mul on the SM2 curve. Captures an affine result point (Qx, Qy) when point_mul's finish pulses.
- Decides whether the point is a valid curve point: both coordinates in [0, p-1] and y^2 ≡ x^3 + a·x + b (mod p).
- Its verdict gates the result before it reaches signature and key-exchange logic.
- Arithmetic is bit-serial modular multiply/add, one bit per clock.

---
 rtl/ecc_point_check.sv | 184 ++++++++++++++++++
 tb/tb_ecc_point_check.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_check.sv
// ecc_point_check: checks that an affine SM2 point (Qx, Qy) from point_mul
// lies on the curve y^2 = x^3 + a*x + b (mod p) and that both coordinates
// are in range. A single bit-serial modular multiplier does one bit per
// clock and is shared by the three products y*y, x*x and (x^2+a)*x.
module ecc_point_check #(
  parameter logic [255:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF,
  parameter logic [255:0] A = P - 256'd3,
  parameter logic [255:0] B = 256'h28E9FA9E9D9F5E344D5A9E4BCF6509A7F39789F515AB8F92DDBCBD414D940E93
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [256:0] Qx,
  input  logic [256:0] Qy,
  output logic         busy,
  output logic         done,
  output logic         on_curve,
  output logic         range_err
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    CHK  = 4'd1,
    MYY  = 4'd2,
    MXX  = 4'd3,
    ADDA = 4'd4,
    MX   = 4'd5,
    ADDB = 4'd6,
    CMP  = 4'd7,
    FIN  = 4'd8
  } state_t;

  state_t       state;
  logic [256:0] x_r;       // latched x, bit 256 kept for the range check
  logic [256:0] y_r;       // latched y
  logic [255:0] t1;        // y^2
  logic [255:0] t2;        // x^2, then x^2 + a
  logic [255:0] t3;        // (x^2 + a)*x, then + b
  logic [255:0] acc;       // running partial product
  logic [7:0]   cnt;       // multiplier bit index, 255 down to 0

  logic [255:0] mcand;
  logic [255:0] mplier;
  logic [255:0] dbl;
  logic [255:0] step;
  logic         out_of_range;

  // (a + b) mod P for a, b < P: one conditional subtract on a 258-bit sum.
  // Used for both the doubling and the accumulate of the serial multiply
  // and for the two coefficient additions.
  function automatic logic [255:0] mod_add(input logic [255:0] a,
                                           input logic [255:0] b);
    logic [257:0] s;
    s = {2'b00, a} + {2'b00, b};
    if (s >= {2'b00, P})
      s = s - {2'b00, P};
    return s[255:0];
  endfunction

  // Operand select for the shared multiplier and one MSB-first step:
  // acc' = 2*acc mod P, then + mcand mod P when the current multiplier bit is set.
  always_comb begin
    mcand  = x_r[255:0];
    mplier = x_r[255:0];
    case (state)
      MYY: begin
        mcand  = y_r[255:0];
        mplier = y_r[255:0];
      end
      MX: begin
        mcand  = t2;
        mplier = x_r[255:0];
      end
      default: ;
    endcase
    dbl  = mod_add(acc, acc);
    step = mplier[cnt] ? mod_add(dbl, mcand) : dbl;
  end

  // Bit 256 set or either coordinate at/above P fails before any arithmetic.
  always_comb begin
    out_of_range = x_r[256] | y_r[256] |
                   (x_r[255:0] >= P) | (y_r[255:0] >= P);
  end

  // Sequencer and datapath registers. The counter wraps 0 -> 255 by itself,
  // so every multiply phase starts at bit 255 without an explicit reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      on_curve  <= 1'b0;
      range_err <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      acc       <= '0;
      cnt       <= 8'hFF;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the previous check, so a start
          // coinciding with done is dropped.
          if (start && !done) begin
            x_r       <= Qx;
            y_r       <= Qy;
            busy      <= 1'b1;
            on_curve  <= 1'b0;
            range_err <= 1'b0;
            state     <= CHK;
          end
        end
        CHK: begin
          acc <= '0;
          cnt <= 8'hFF;
          if (out_of_range) begin
            range_err <= 1'b1;
            on_curve  <= 1'b0;
            state     <= FIN;
          end else begin
            state <= MYY;
          end
        end
        MYY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd0) begin
            t1    <= step;
            acc   <= '0;
            state <= MXX;
          end else begin
            acc <= step;
          end
        end
        MXX: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd0) begin
            t2    <= step;
            acc   <= '0;
            state <= ADDA;
          end else begin
            acc <= step;
          end
        end
        ADDA: begin
          t2    <= mod_add(t2, A);
          state <= MX;
        end
        MX: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd0) begin
            t3    <= step;
            acc   <= '0;
            state <= ADDB;
          end else begin
            acc <= step;
          end
        end
        ADDB: begin
          t3    <= mod_add(t3, B);
          state <= CMP;
        end
        CMP: begin
          on_curve  <= (t1 == t3);
          range_err <= 1'b0;
          state     <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_check.sv
// Bench for ecc_point_check: fixed vector table, hand sequences for the
// busy/reset corners, chained scalar-multiple points and random points
// judged by a wide-arithmetic curve model.
module tb_ecc_point_check;

  localparam logic [255:0] P  = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [255:0] A  = P - 256'd3;
  localparam logic [255:0] B  = 256'h28E9FA9E9D9F5E344D5A9E4BCF6509A7F39789F515AB8F92DDBCBD414D940E93;
  localparam logic [255:0] GX = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] GY = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
  localparam int LAT_FULL = 774;
  localparam int LAT_RNG  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [256:0] Qx = '0;
  logic [256:0] Qy = '0;
  logic         busy, done, on_curve, range_err;

  int total = 0;
  int bad   = 0;

  ecc_point_check dut (
    .clk(clk), .rst(rst), .start(start), .Qx(Qx), .Qy(Qy),
    .busy(busy), .done(done), .on_curve(on_curve), .range_err(range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model: plain modular arithmetic ----------------
  function automatic logic [255:0] mmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'b0, a} * {256'b0, b};
    t = t % {256'b0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] madd(input logic [255:0] a, input logic [255:0] b);
    logic [257:0] t;
    t = ({2'b0, a} + {2'b0, b}) % {2'b0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] msub(input logic [255:0] a, input logic [255:0] b);
    return madd(a, P - b);
  endfunction

  function automatic logic [255:0] mpow(input logic [255:0] a, input logic [255:0] e);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mmul(r, r);
      if (e[i]) r = mmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [255:0] rhs(input logic [255:0] x);
    return madd(madd(mmul(mmul(x, x), x), mmul(A, x)), B);
  endfunction

  task automatic ref_verdict(input logic [256:0] x, input logic [256:0] y,
                             output bit on, output bit rng);
    rng = (x >= {1'b0, P}) || (y >= {1'b0, P});
    on  = !rng && (mmul(y[255:0], y[255:0]) == rhs(x[255:0]));
  endtask

  // Affine point addition / doubling, stand-in for point_mul.
  task automatic pt_add(input logic [255:0] x1, input logic [255:0] y1,
                        input logic [255:0] x2, input logic [255:0] y2,
                        output logic [255:0] x3, output logic [255:0] y3);
    logic [255:0] num, den, lam;
    if (x1 == x2) begin
      num = madd(mmul(256'd3, mmul(x1, x1)), A);
      den = madd(y1, y1);
    end else begin
      num = msub(y2, y1);
      den = msub(x2, x1);
    end
    lam = mmul(num, mpow(den, P - 256'd2));
    x3  = msub(msub(mmul(lam, lam), x1), x2);
    y3  = msub(mmul(lam, msub(x1, x3)), y1);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- one check transaction ----------------
  // inj_at > 0: pulse start with inj_x/1 after that many edges (must be ignored).
  // A start is also driven during the done cycle and must be ignored too.
  task automatic run_chk(input string nm, input logic [256:0] qx, input logic [256:0] qy,
                         input bit eon, input bit erng, input int elat,
                         input int inj_at, input logic [256:0] inj_x);
    int n;
    bit busy_ok;
    @(negedge clk);
    Qx = qx; Qy = qy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    chk({nm, " accept busy/done/on/rng"}, {28'd0, busy, done, on_curve, range_err}, 32'b1000);
    busy_ok = 1'b1;
    while (!done && n < 2000) begin
      if (!busy) busy_ok = 1'b0;
      if (n == inj_at) begin
        Qx = inj_x; Qy = 257'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy held"}, {31'd0, busy_ok}, 32'd1);
    chk({nm, " on_curve"}, {31'd0, on_curve}, {31'd0, eon});
    chk({nm, " range_err"}, {31'd0, range_err}, {31'd0, erng});
    chk({nm, " busy at done"}, {31'd0, busy}, 32'd0);
    // start during done cycle, with a range-failing operand
    Qx = {1'b0, P}; Qy = 257'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " post-done busy/done/on/rng"}, {28'd0, busy, done, on_curve, range_err},
        {28'd0, 1'b0, 1'b0, eon, erng});
  endtask

  typedef struct {
    logic [256:0] qx;
    logic [256:0] qy;
    bit           on;
    bit           rng;
    int           lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [255:0] x2, y2, x3, y3, x5, y5, rx, ry, r;
    logic [256:0] vx, vy;
    bit eon, erng;
    bit saw_done, saw_busy;
    int kind;

    tbl[0] = '{{1'b0, GX}, {1'b0, GY}, 1'b1, 1'b0, LAT_FULL};
    tbl[1] = '{{1'b0, GX}, {1'b0, GY ^ 256'd1}, 1'b0, 1'b0, LAT_FULL};
    tbl[2] = '{{1'b0, P}, 257'd1, 1'b0, 1'b1, LAT_RNG};
    tbl[3] = '{{1'b0, P}, {1'b1, 256'd1}, 1'b0, 1'b1, LAT_RNG};
    tbl[4] = '{257'd0, 257'd0, 1'b0, 1'b0, LAT_FULL};
    tbl[5] = '{{1'b0, GX}, {1'b0, GY}, 1'b1, 1'b0, LAT_FULL};
    tbl[6] = '{{1'b0, GX}, {1'b0, P}, 1'b0, 1'b1, LAT_RNG};
    tbl[7] = '{{1'b1, GX}, {1'b0, GY}, 1'b0, 1'b1, LAT_RNG};
    tbl[8] = '{{1'b0, GX}, {1'b0, P - GY}, 1'b1, 1'b0, LAT_FULL};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {28'd0, busy, done, on_curve, range_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_chk($sformatf("vec%0d", i), tbl[i].qx, tbl[i].qy, tbl[i].on, tbl[i].rng,
              tbl[i].lat, 0, '0);

    // start while busy at cycle 100 is ignored
    run_chk("busy-start", {1'b0, GX}, {1'b0, GY}, 1'b1, 1'b0, LAT_FULL, 100, {1'b0, P});

    // reset at cycle 400 abandons the check
    @(negedge clk);
    Qx = {1'b0, GX}; Qy = {1'b0, GY}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (399) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid reset outputs", {28'd0, busy, done, on_curve, range_err}, 32'd0);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (800) begin
      @(posedge clk); #1;
      saw_done |= done;
      saw_busy |= busy;
    end
    chk("no done after reset", {31'd0, saw_done}, 32'd0);
    chk("no busy after reset", {31'd0, saw_busy}, 32'd0);
    run_chk("after reset", {1'b0, GX}, {1'b0, GY}, 1'b1, 1'b0, LAT_FULL, 0, '0);

    // point_mul results: scalar multiples of G
    pt_add(GX, GY, GX, GY, x2, y2);
    pt_add(x2, y2, GX, GY, x3, y3);
    pt_add(x3, y3, x2, y2, x5, y5);
    run_chk("2G", {1'b0, x2}, {1'b0, y2}, 1'b1, 1'b0, LAT_FULL, 0, '0);
    run_chk("3G", {1'b0, x3}, {1'b0, y3}, 1'b1, 1'b0, LAT_FULL, 0, '0);
    run_chk("5G", {1'b0, x5}, {1'b0, y5}, 1'b1, 1'b0, LAT_FULL, 0, '0);

    // boundary: x = P-1 in range, judged by the model
    vx = {1'b0, P - 256'd1};
    vy = {1'b0, mpow(rhs(P - 256'd1), (P >> 2) + 256'd1)};
    ref_verdict(vx, vy, eon, erng);
    run_chk("x=P-1", vx, vy, eon, erng, erng ? LAT_RNG : LAT_FULL, 0, '0);

    // random points
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      rx = rnd256() % P;
      ry = rnd256() % P;
      if (kind == 0) begin
        r  = rhs(rx);
        ry = mpow(r, (P >> 2) + 256'd1);  // sqrt, valid because P = 3 mod 4
        if (mmul(ry, ry) != r) ry = ry ^ 256'd1;
        vx = {1'b0, rx}; vy = {1'b0, ry};
      end else if (kind == 1) begin
        vx = {1'b0, rx}; vy = {1'b0, ry};
      end else begin
        vx = {1'b0, rx}; vy = {1'b0, ry};
        if ($urandom_range(0, 1) == 0) vx = {1'b0, P} + 257'(rx[15:0]);
        else vy[256] = 1'b1;
      end
      ref_verdict(vx, vy, eon, erng);
      run_chk($sformatf("rand%0d k%0d", i, kind), vx, vy, eon, erng,
              erng ? LAT_RNG : LAT_FULL, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
